// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store access unit with address-exception detection and the M/W pipeline register
//   clk, reset                   : clock, synchronous active-high reset (clears W-stage state only)
//   valid_m, flush_m, pc_m       : M-stage slot valid, kill side effects, M-stage PC
//   mem_op, addr_m, wdata_m      : access type (0 none, 1 LW .. 8 SB), effective address, store source
//   dm_a, dm_wd, dm_be, dm_we    : data memory address, lane-shifted store data, byte enables, write strobe
//   dm_rd, dev_rd                : combinational read words from data memory and timer devices
//   dev_we                       : timer device write strobe
//   exc_m, exc_code_m            : address exception flag and code (4 AdEL, 5 AdES)
//   valid_w, pc_w, ld_w, rdata_w : W-stage valid, PC, load flag and extended load result
module mem_access_unit #(
    parameter logic [31:0] DM_LIMIT  = 32'h0000_3000,
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic        flush_m,
    input  logic [31:0] pc_m,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic [31:0] dm_a,
    output logic [31:0] dm_wd,
    output logic [3:0]  dm_be,
    output logic        dm_we,
    input  logic [31:0] dm_rd,
    output logic        dev_we,
    input  logic [31:0] dev_rd,
    output logic        exc_m,
    output logic [4:0]  exc_code_m,
    output logic        valid_w,
    output logic [31:0] pc_w,
    output logic        ld_w,
    output logic [31:0] rdata_w
);
    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [31:0] DEV0_END = DEV0_BASE + 32'd12;
    localparam logic [31:0] DEV1_END = DEV1_BASE + 32'd12;
    localparam logic [31:0] DEV0_CNT = DEV0_BASE + 32'd8;
    localparam logic [31:0] DEV1_CNT = DEV1_BASE + 32'd8;

    logic [1:0]  o;
    logic        is_load, is_store, is_word, is_half, is_byte;
    logic        in_dm, in_dev, in_none, count_hit, misal, ld_ok, st_ok;
    logic [3:0]  be_raw;
    logic [31:0] rd, ext;
    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        o         = addr_m[1:0];
        is_load   = mem_op >= OP_LW && mem_op <= OP_LBU;
        is_store  = mem_op >= OP_SW && mem_op <= OP_SB;
        is_word   = mem_op == OP_LW || mem_op == OP_SW;
        is_half   = mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH;
        is_byte   = mem_op == OP_LB || mem_op == OP_LBU || mem_op == OP_SB;
        in_dm     = addr_m < DM_LIMIT;
        in_dev    = (addr_m >= DEV0_BASE && addr_m < DEV0_END) || (addr_m >= DEV1_BASE && addr_m < DEV1_END);
        in_none   = !in_dm && !in_dev;
        // the timer count word is read-only; word granularity suffices since sub-word device access already faults
        count_hit = addr_m[31:2] == DEV0_CNT[31:2] || addr_m[31:2] == DEV1_CNT[31:2];
        misal     = (is_word && o != 2'd0) || (is_half && o[0]);
        exc_m     = valid_m && (is_load || is_store) &&
                    (misal || in_none || (in_dev && !is_word) || (is_store && count_hit));
        exc_code_m = exc_m ? (is_load ? 5'd4 : 5'd5) : 5'd0;
        st_ok     = is_store && valid_m && !exc_m && !flush_m;
        ld_ok     = is_load && valid_m && !exc_m && !flush_m;
        dm_we     = st_ok && in_dm;
        dev_we    = st_ok && in_dev;
        be_raw    = is_word ? 4'b1111 : is_half ? (o[1] ? 4'b1100 : 4'b0011) : is_byte ? (4'b0001 << o) : 4'b0000;
        // enables only accompany an actual DM write, so loads, faults, flushes and device stores present 0000
        dm_be     = dm_we ? be_raw : 4'b0000;
        dm_a      = addr_m;
        dm_wd     = is_half ? {2{wdata_m[15:0]}} : is_byte ? {4{wdata_m[7:0]}} : wdata_m;
        rd        = in_dev ? dev_rd : dm_rd;
        half_v    = o[1] ? rd[31:16] : rd[15:0];
        byte_v    = rd[{o, 3'b000} +: 8];
        ext       = mem_op == OP_LW  ? rd :
                    mem_op == OP_LH  ? {{16{half_v[15]}}, half_v} :
                    mem_op == OP_LHU ? {16'h0000, half_v} :
                    mem_op == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
                    mem_op == OP_LBU ? {24'h000000, byte_v} : 32'h0000_0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_w <= 1'b0;
            pc_w    <= 32'h0000_0000;
            ld_w    <= 1'b0;
            rdata_w <= 32'h0000_0000;
        end else begin
            valid_w <= valid_m && !flush_m && !exc_m;
            pc_w    <= pc_m;
            ld_w    <= ld_ok;
            rdata_w <= ld_ok ? ext : 32'h0000_0000;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed self-checking bench for mem_access_unit against a byte-level memory model
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, flush_m;
    logic [31:0] pc_m, addr_m, wdata_m;
    logic [3:0]  mem_op;
    logic [31:0] dm_a, dm_wd, dm_rd, dev_rd, pc_w, rdata_w;
    logic [3:0]  dm_be;
    logic        dm_we, dev_we, exc_m, valid_w, ld_w;
    logic [4:0]  exc_code_m;
    int total = 0;
    int bad = 0;
    logic [31:0] dm_mem [0:3071];
    logic [7:0]  ref_bytes [int];
    logic [31:0] dev_val;
    logic [31:0] s_a, s_wd, w_pc, w_rdata;
    logic [3:0]  s_be;
    logic [4:0]  s_code;
    logic        s_dm_we, s_dev_we, s_exc, w_valid, w_ld;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .valid_m(valid_m), .flush_m(flush_m), .pc_m(pc_m),
        .mem_op(mem_op), .addr_m(addr_m), .wdata_m(wdata_m), .dm_a(dm_a), .dm_wd(dm_wd),
        .dm_be(dm_be), .dm_we(dm_we), .dm_rd(dm_rd), .dev_we(dev_we), .dev_rd(dev_rd),
        .exc_m(exc_m), .exc_code_m(exc_code_m), .valid_w(valid_w), .pc_w(pc_w),
        .ld_w(ld_w), .rdata_w(rdata_w)
    );

    always #5 clk = ~clk;

    assign dm_rd  = (dm_a < 32'h3000) ? dm_mem[dm_a[13:2]] : 32'hDEAD_BEEF;
    assign dev_rd = dev_val;

    always @(posedge clk) begin
        if (dm_we && dm_a < 32'h3000)
            dm_mem[dm_a[13:2]] <= (dm_mem[dm_a[13:2]] & ~{{8{dm_be[3]}}, {8{dm_be[2]}}, {8{dm_be[1]}}, {8{dm_be[0]}}})
                                | (dm_wd & {{8{dm_be[3]}}, {8{dm_be[2]}}, {8{dm_be[1]}}, {8{dm_be[0]}}});
    end

    function automatic int m_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            4'd4, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic bit m_load(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd5;
    endfunction

    function automatic bit m_store(input logic [3:0] op);
        return op >= 4'd6 && op <= 4'd8;
    endfunction

    function automatic int m_region(input logic [31:0] a);
        if (a < 32'h3000) return 0;
        if ((a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B)) return 1;
        return 2;
    endfunction

    function automatic logic [4:0] m_code(input bit v, input logic [3:0] op, input logic [31:0] a);
        int unsigned sz;
        bit fault;
        sz = m_size(op);
        if (!v || sz == 0) return 5'd0;
        fault = (a % sz != 0) || m_region(a) == 2 || (m_region(a) == 1 && sz != 4) ||
                (m_store(op) && (a == 32'h7F08 || a == 32'h7F18));
        return fault ? (m_load(op) ? 5'd4 : 5'd5) : 5'd0;
    endfunction

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ref_bytes.exists(int'(a)) ? ref_bytes[int'(a)] : 8'h00;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [3:0] op, input logic [31:0] a, input logic [31:0] dev);
        logic [31:0] base, w, v;
        int sz;
        sz = m_size(op);
        base = a & ~32'h3;
        w = m_region(a) == 1 ? dev : {rb(base + 3), rb(base + 2), rb(base + 1), rb(base)};
        v = w >> (8 * (a % 4));
        if (sz == 1) v = (op == 4'd4 && v[7]) ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
        if (sz == 2) v = (op == 4'd2 && v[15]) ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
        return v;
    endfunction

    function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] wd);
        return m_size(op) == 2 ? {2{wd[15:0]}} : m_size(op) == 1 ? {4{wd[7:0]}} : wd;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
        int msk;
        msk = ((1 << m_size(op)) - 1) << (a % 4);
        return msk[3:0];
    endfunction

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input bit v, input bit fl, input logic [31:0] pc);
        @(negedge clk);
        mem_op = op; addr_m = a; wdata_m = wd; valid_m = v; flush_m = fl; pc_m = pc;
        #2;
        s_a = dm_a; s_wd = dm_wd; s_be = dm_be; s_dm_we = dm_we; s_dev_we = dev_we;
        s_exc = exc_m; s_code = exc_code_m;
        @(posedge clk);
        #1;
        w_valid = valid_w; w_pc = pc_w; w_ld = ld_w; w_rdata = rdata_w;
        if (m_store(op) && v && !fl && m_code(v, op, a) == 5'd0 && m_region(a) == 0)
            for (int k = 0; k < m_size(op); k++) ref_bytes[int'(a) + k] = wd[8*k +: 8];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", w_valid); end
        total++; if (w_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", w_pc); end
        total++; if (w_ld !== 1'b0) begin bad++; $display("FAIL rst_ld got=%b exp=0", w_ld); end
        total++; if (w_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", w_rdata); end
        reset = 1'b0;
        step(4'd6, 32'h44, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h3FC);
        reset = 1'b1;
        step(4'd1, 32'h44, 32'h0, 1'b1, 1'b0, 32'h400);
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL rst_ld_valid got=%b exp=0", w_valid); end
        total++; if (w_pc !== 32'h0) begin bad++; $display("FAIL rst_ld_pc got=%h exp=0", w_pc); end
        total++; if (w_ld !== 1'b0) begin bad++; $display("FAIL rst_ld_ld got=%b exp=0", w_ld); end
        total++; if (w_rdata !== 32'h0) begin bad++; $display("FAIL rst_ld_rdata got=%h exp=0", w_rdata); end
        step(4'd1, 32'h46, 32'h0, 1'b1, 1'b0, 32'h404);
        total++; if (s_code !== 5'd4) begin bad++; $display("FAIL rst_comb_code got=%0d exp=4", s_code); end
        reset = 1'b0;
        step(4'd1, 32'h44, 32'h0, 1'b1, 1'b0, 32'h408);
        total++; if (w_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL post_rst_rdata got=%h exp=cafef00d", w_rdata); end
        total++; if (w_pc !== 32'h408) begin bad++; $display("FAIL post_rst_pc got=%h exp=408", w_pc); end
    endtask

    task automatic test_store_load();
        step(4'd6, 32'h10, 32'h1234_5678, 1'b1, 1'b0, 32'h100);
        total++; if (s_dm_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%b exp=1", s_dm_we); end
        total++; if (s_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b exp=1111", s_be); end
        total++; if (s_wd !== 32'h1234_5678) begin bad++; $display("FAIL sw_wd got=%h exp=12345678", s_wd); end
        total++; if (w_ld !== 1'b0 || w_rdata !== 32'h0) begin bad++; $display("FAIL sw_w ld=%b rdata=%h exp ld=0 rdata=0", w_ld, w_rdata); end
        step(4'd1, 32'h10, 32'h0, 1'b1, 1'b0, 32'h104);
        total++; if (w_rdata !== 32'h1234_5678) begin bad++; $display("FAIL lw_rdata got=%h exp=12345678", w_rdata); end
        total++; if (w_ld !== 1'b1 || w_valid !== 1'b1) begin bad++; $display("FAIL lw_flags ld=%b valid=%b exp 1 1", w_ld, w_valid); end
        step(4'd8, 32'h13, 32'h0000_00AB, 1'b1, 1'b0, 32'h108);
        total++; if (s_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", s_be); end
        total++; if (s_wd !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wd got=%h exp=abababab", s_wd); end
        step(4'd4, 32'h13, 32'h0, 1'b1, 1'b0, 32'h10C);
        total++; if (w_rdata !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffffab", w_rdata); end
        step(4'd5, 32'h13, 32'h0, 1'b1, 1'b0, 32'h110);
        total++; if (w_rdata !== 32'h0000_00AB) begin bad++; $display("FAIL lbu_rdata got=%h exp=000000ab", w_rdata); end
        step(4'd7, 32'h12, 32'h0000_8001, 1'b1, 1'b0, 32'h114);
        total++; if (s_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", s_be); end
        total++; if (s_wd !== 32'h8001_8001) begin bad++; $display("FAIL sh_wd got=%h exp=80018001", s_wd); end
        step(4'd2, 32'h12, 32'h0, 1'b1, 1'b0, 32'h118);
        total++; if (w_rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_rdata got=%h exp=ffff8001", w_rdata); end
        step(4'd3, 32'h12, 32'h0, 1'b1, 1'b0, 32'h11C);
        total++; if (w_rdata !== 32'h0000_8001) begin bad++; $display("FAIL lhu_rdata got=%h exp=00008001", w_rdata); end
        step(4'd1, 32'h10, 32'h0, 1'b1, 1'b0, 32'h120);
        total++; if (w_rdata !== 32'h8001_5678) begin bad++; $display("FAIL merged_word got=%h exp=80015678", w_rdata); end
    endtask

    task automatic test_exceptions();
        step(4'd1, 32'h6, 32'h0, 1'b1, 1'b0, 32'h200);
        total++; if (s_exc !== 1'b1 || s_code !== 5'd4) begin bad++; $display("FAIL lw_misal exc=%b code=%0d exp 1 4", s_exc, s_code); end
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL lw_misal_valid got=%b exp=0", w_valid); end
        step(4'd7, 32'h5, 32'hFFFF, 1'b1, 1'b0, 32'h204);
        total++; if (s_code !== 5'd5) begin bad++; $display("FAIL sh_misal_code got=%0d exp=5", s_code); end
        total++; if (s_dm_we !== 1'b0 || s_be !== 4'b0000) begin bad++; $display("FAIL sh_misal_we we=%b be=%b exp 0 0000", s_dm_we, s_be); end
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL sh_misal_valid got=%b exp=0", w_valid); end
        step(4'd6, 32'h3000, 32'h1, 1'b1, 1'b0, 32'h208);
        total++; if (s_code !== 5'd5 || s_dm_we !== 1'b0 || s_be !== 4'b0000) begin bad++; $display("FAIL sw_limit code=%0d we=%b be=%b exp 5 0 0000", s_code, s_dm_we, s_be); end
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL sw_limit_valid got=%b exp=0", w_valid); end
        step(4'd1, 32'h2FFC, 32'h0, 1'b1, 1'b0, 32'h20C);
        total++; if (s_exc !== 1'b0 || w_valid !== 1'b1) begin bad++; $display("FAIL lw_last exc=%b valid=%b exp 0 1", s_exc, w_valid); end
    endtask

    task automatic test_device();
        dev_val = 32'h1357_2468;
        step(4'd6, 32'h7F04, 32'h1, 1'b1, 1'b0, 32'h300);
        total++; if (s_dev_we !== 1'b1 || s_dm_we !== 1'b0) begin bad++; $display("FAIL dev_sw dev_we=%b dm_we=%b exp 1 0", s_dev_we, s_dm_we); end
        total++; if (s_be !== 4'b0000 || s_exc !== 1'b0) begin bad++; $display("FAIL dev_sw_be be=%b exc=%b exp 0000 0", s_be, s_exc); end
        step(4'd6, 32'h7F08, 32'h1, 1'b1, 1'b0, 32'h304);
        total++; if (s_code !== 5'd5 || s_dev_we !== 1'b0) begin bad++; $display("FAIL dev_count code=%0d dev_we=%b exp 5 0", s_code, s_dev_we); end
        step(4'd4, 32'h7F00, 32'h0, 1'b1, 1'b0, 32'h308);
        total++; if (s_code !== 5'd4) begin bad++; $display("FAIL dev_lb code=%0d exp=4", s_code); end
        step(4'd1, 32'h7F14, 32'h0, 1'b1, 1'b0, 32'h30C);
        total++; if (w_rdata !== 32'h1357_2468 || w_ld !== 1'b1) begin bad++; $display("FAIL dev_lw rdata=%h ld=%b exp 13572468 1", w_rdata, w_ld); end
        step(4'd1, 32'h7F0C, 32'h0, 1'b1, 1'b0, 32'h310);
        total++; if (s_code !== 5'd4) begin bad++; $display("FAIL dev_gap code=%0d exp=4", s_code); end
        step(4'd6, 32'h7F1C, 32'h0, 1'b1, 1'b0, 32'h314);
        total++; if (s_code !== 5'd5) begin bad++; $display("FAIL dev1_end code=%0d exp=5", s_code); end
    endtask

    task automatic test_flush();
        step(4'd6, 32'h20, 32'h55AA_55AA, 1'b1, 1'b1, 32'h400);
        total++; if (s_dm_we !== 1'b0 || s_be !== 4'b0000 || s_exc !== 1'b0) begin bad++; $display("FAIL flush_sw we=%b be=%b exc=%b exp 0 0000 0", s_dm_we, s_be, s_exc); end
        total++; if (w_valid !== 1'b0) begin bad++; $display("FAIL flush_sw_valid got=%b exp=0", w_valid); end
        step(4'd1, 32'h20, 32'h0, 1'b1, 1'b0, 32'h404);
        total++; if (w_rdata !== 32'h0) begin bad++; $display("FAIL flush_no_write got=%h exp=0", w_rdata); end
        step(4'd6, 32'h21, 32'h1, 1'b1, 1'b1, 32'h408);
        total++; if (s_exc !== 1'b1 || s_code !== 5'd5 || w_valid !== 1'b0) begin bad++; $display("FAIL flush_exc exc=%b code=%0d valid=%b exp 1 5 0", s_exc, s_code, w_valid); end
        step(4'd1, 32'h44, 32'h0, 1'b1, 1'b1, 32'h40C);
        total++; if (w_ld !== 1'b0 || w_rdata !== 32'h0) begin bad++; $display("FAIL flush_lw ld=%b rdata=%h exp 0 0", w_ld, w_rdata); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, wd;
            a = {$urandom_range(0, 3071), 2'b00};
            wd = $urandom;
            step(4'd6, a, wd, 1'b1, 1'b0, 32'h500);
            step(4'd1, a, 32'h0, 1'b1, 1'b0, 32'h504);
            total++; if (w_rdata !== wd) begin bad++; $display("FAIL b2b addr=%h got=%h exp=%h", a, w_rdata, wd); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            logic [31:0] a, wd, pc, e_rd;
            logic [4:0] e_code;
            logic [3:0] e_be;
            bit v, fl, ok, e_dm_we, e_dev_we, e_ld;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 63);
                1: a = 32'h2FF0 + $urandom_range(0, 31);
                2: a = 32'h7F00 + $urandom_range(0, 31);
                default: a = $urandom;
            endcase
            wd = $urandom; pc = $urandom; dev_val = $urandom;
            v = $urandom_range(0, 7) != 0;
            fl = $urandom_range(0, 7) == 0;
            e_code = m_code(v, op, a);
            ok = v && !fl && e_code == 5'd0;
            e_dm_we = ok && m_store(op) && m_region(a) == 0;
            e_dev_we = ok && m_store(op) && m_region(a) == 1;
            e_be = e_dm_we ? m_be(op, a) : 4'b0000;
            e_ld = ok && m_load(op);
            e_rd = e_ld ? m_rdata(op, a, dev_val) : 32'h0;
            step(op, a, wd, v, fl, pc);
            total++; if (s_a !== a) begin bad++; $display("FAIL rnd_a op=%0d got=%h exp=%h", op, s_a, a); end
            total++; if (s_code !== e_code || s_exc !== (e_code != 5'd0)) begin bad++; $display("FAIL rnd_exc op=%0d a=%h code=%0d exc=%b exp code=%0d", op, a, s_code, s_exc, e_code); end
            total++; if (s_dm_we !== e_dm_we || s_dev_we !== e_dev_we) begin bad++; $display("FAIL rnd_we op=%0d a=%h dm=%b dev=%b exp %b %b", op, a, s_dm_we, s_dev_we, e_dm_we, e_dev_we); end
            total++; if (s_be !== e_be) begin bad++; $display("FAIL rnd_be op=%0d a=%h got=%b exp=%b", op, a, s_be, e_be); end
            if (m_store(op)) begin
                total++; if (s_wd !== m_wd(op, wd)) begin bad++; $display("FAIL rnd_wd op=%0d got=%h exp=%h", op, s_wd, m_wd(op, wd)); end
            end
            total++; if (w_valid !== ok || w_pc !== pc || w_ld !== e_ld) begin bad++; $display("FAIL rnd_w op=%0d valid=%b pc=%h ld=%b exp %b %h %b", op, w_valid, w_pc, w_ld, ok, pc, e_ld); end
            total++; if (w_rdata !== e_rd) begin bad++; $display("FAIL rnd_rdata op=%0d a=%h got=%h exp=%h", op, a, w_rdata, e_rd); end
        end
    endtask

    initial begin
        for (int i = 0; i < 3072; i++) dm_mem[i] = 32'h0;
        reset = 1'b1; valid_m = 1'b0; flush_m = 1'b0; pc_m = 32'h0;
        mem_op = 4'd0; addr_m = 32'h0; wdata_m = 32'h0; dev_val = 32'h0;
        test_reset();
        test_store_load();
        test_exceptions();
        test_device();
        test_flush();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
